// File: rtl/math_divider_pkg.sv
// math_divider_pkg: shared state encoding, default widths and helpers for the sequential divider
package math_divider_pkg;
    localparam int XWIDTH_DEF = 8;
    localparam int YWIDTH_DEF = 4;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
    function automatic int clog2(input int v);
        int w;
        w = 1;
        while ((1 << w) < v) w++;
        return w;
    endfunction
endpackage

// File: rtl/math_divider_attempt_subtr_stage.sv
// math_divider_attempt_subtr_stage: one restoring-division step (shift in a dividend bit, try to subtract y)
// Ports: rem_in/x_bit/y in; rem_out (next partial remainder), q_bit (quotient bit) out.
module math_divider_attempt_subtr_stage #(
    parameter int yWIDTH = 4
) (
    input  logic [yWIDTH-1:0] rem_in,
    input  logic              x_bit,
    input  logic [yWIDTH-1:0] y,
    output logic [yWIDTH-1:0] rem_out,
    output logic              q_bit
);
    logic [yWIDTH:0]   trial;
    logic [yWIDTH-1:0] diff;
    always_comb begin
        trial   = {rem_in, x_bit};
        q_bit   = trial >= {1'b0, y};
        // the difference is below y whenever it is taken, so its low bits are exact
        diff    = trial[yWIDTH-1:0] - y;
        rem_out = q_bit ? diff : trial[yWIDTH-1:0];
    end
endmodule

// File: rtl/math_divider_seq_ctrl.sv
// math_divider_seq_ctrl: valid/ready sequencer computing one quotient bit per cycle, MSB first
// Ports: clk, rst (async, active-high); in_valid/in_ready/x/y operand side;
//        out_valid/out_ready/q/r/div0 result side; busy = not idle.
// Optional: MATH_DIVIDER_SEQ_EARLY_EXIT_EN finishes x<y operands at acceptance.
module math_divider_seq_ctrl
    import math_divider_pkg::*;
#(
    parameter int xWIDTH = XWIDTH_DEF,
    parameter int yWIDTH = YWIDTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [xWIDTH-1:0] x,
    input  logic [yWIDTH-1:0] y,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [xWIDTH-1:0] q,
    output logic [yWIDTH-1:0] r,
    output logic              div0,
    output logic              busy
);
    localparam int CW = clog2(xWIDTH);

    state_t            state, state_nx;
    logic [xWIDTH-1:0] x_r, q_r;
    logic [yWIDTH-1:0] y_r, rem, rem_nx;
    logic [CW-1:0]     cnt;
    logic              div0_r, q_bit, accept, fast;

    assign accept = in_valid & in_ready;

`ifdef MATH_DIVIDER_SEQ_EARLY_EXIT_EN
    // x<y already has quotient 0 and remainder x
    assign fast = (y == '0) | (x < {{(xWIDTH-yWIDTH){1'b0}}, y});
`else
    assign fast = (y == '0);
`endif

    math_divider_attempt_subtr_stage #(.yWIDTH(yWIDTH)) u_stage (
        .rem_in (rem),
        .x_bit  (x_r[cnt]),
        .y      (y_r),
        .rem_out(rem_nx),
        .q_bit  (q_bit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state == IDLE ? (accept ? (fast ? DONE : RUN) : IDLE)
                 : state == RUN  ? (cnt == '0 ? DONE : RUN)
                 : (out_ready ? IDLE : DONE);
    end

    always_comb begin
        in_ready  = state == IDLE;
        out_valid = state == DONE;
        busy      = state != IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_r    <= '0;
            y_r    <= '0;
            q_r    <= '0;
            rem    <= '0;
            cnt    <= '0;
            div0_r <= 1'b0;
        end else if (accept) begin
            x_r    <= x;
            y_r    <= y;
            cnt    <= CW'(xWIDTH - 1);
            div0_r <= y == '0;
            q_r    <= y == '0 ? '1 : '0;
            // shortcut results report x's low bits as the remainder
            rem    <= fast ? x[yWIDTH-1:0] : '0;
        end else if (state == RUN) begin
            q_r[cnt] <= q_bit;
            rem      <= rem_nx;
            cnt      <= cnt - 1'b1;
        end
    end

    assign q    = q_r;
    assign r    = rem;
    assign div0 = div0_r;
endmodule

// File: tb/tb_math_divider_seq_ctrl.sv
// tb_math_divider_seq_ctrl: scoreboard bench for the sequential divider against an arithmetic model
module tb_math_divider_seq_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b1;
    logic [7:0] x = '0;
    logic [3:0] y = '0;
    logic       in_ready, out_valid, div0, busy;
    logic [7:0] q;
    logic [3:0] r;

    math_divider_seq_ctrl dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .y(y), .out_valid(out_valid), .out_ready(out_ready),
        .q(q), .r(r), .div0(div0), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] q;
        logic [3:0] r;
        logic       d;
        int         lat;
        int         acc;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   stall_n = 0;
    bit   rand_stall = 0;
    bit   have = 0;
    bit   cur_ok = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic exp_t model(input bit [7:0] a, input bit [3:0] b);
        exp_t e;
        e.q = b == 0 ? 8'hFF : a / b;
        e.r = b == 0 ? a[3:0] : 4'(a % b);
        e.d = b == 0;
`ifdef MATH_DIVIDER_SEQ_EARLY_EXIT_EN
        e.lat = (b == 0 || a < b) ? 1 : 9;
`else
        e.lat = b == 0 ? 1 : 9;
`endif
        e.acc = 0;
        return e;
    endfunction

    task automatic send(input bit [7:0] a, input bit [3:0] b);
        int   n;
        exp_t e;
        n = 0;
        @(negedge clk);
        x = a;
        y = b;
        in_valid = 1'b1;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got in_ready=0 expected 1 for x=%0d y=%0d", a, b);
            in_valid = 1'b0;
            return;
        end
        e = model(a, b);
        e.acc = cyc + 1;
        sb.push_back(e);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || out_valid) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
        end
    endtask

    // monitor: pops an expectation when a result appears and rechecks it every stalled cycle
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (out_valid) begin
                if (!have) begin
                    have = 1;
                    if (sb.size() == 0) begin
                        cur_ok = 0;
                        total++;
                        bad++;
                        $display("FAIL unexpected_result: got q=%0d r=%0d expected no result", q, r);
                    end else begin
                        cur_ok = 1;
                        cur = sb.pop_front();
                        chk("latency", cyc - cur.acc + 1, cur.lat);
                    end
                end
                if (cur_ok) begin
                    chk("q", q, cur.q);
                    chk("r", r, cur.r);
                    chk("div0", div0, cur.d);
                end
                chk("in_ready_in_done", in_ready, 0);
            end
            out_ready = stall_n > 0 ? 1'b0 : rand_stall ? ($urandom_range(3) != 0) : 1'b1;
            if (stall_n > 0 && out_valid) stall_n--;
            if (out_valid && out_ready) have = 0;
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL global_timeout: got time %0t expected earlier finish", $time);
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_q", q, 0);
        chk("rst_r", r, 0);
        chk("rst_div0", div0, 0);
        rst = 1'b0;

        send(200, 7);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) break;
            chk("busy_run", busy, 1);
        end
        drain();

        send(37, 0);
        drain();
        send(5, 9);
        drain();

        stall_n = 5;
        send(200, 7);
        for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
        x = 8'd1;
        y = 4'd1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = ~in_valid;
        end
        in_valid = 1'b0;
        send(99, 3);
        drain();

        send(200, 7);
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_in_ready", in_ready, 1);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_q", q, 0);
        chk("abort_r", r, 0);
        chk("abort_div0", div0, 0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_idle", busy, 0);
        send(255, 15);
        drain();

        rand_stall = 1;
        for (int a = 0; a < 256; a++)
            for (int b = 1; b < 16; b++)
                send(8'(a), 4'(b));
        for (int i = 0; i < 30; i++)
            send(8'($urandom), 4'($urandom_range(15)));
        drain();
        $display("EOT");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/math_divider_seq_ctrl.md
Name: math_divider_seq_ctrl

Overview:
- Multi-cycle sequencer for the attempt-subtraction divider. It reuses one compare/subtract stage for xWIDTH cycles instead of unrolling xWIDTH rows.
- Computes one quotient bit per cycle, MSB first.
- Valid/ready handshakes on both the operand side and the result side.
- Sits between the math front-end and the result consumers wherever area matters more than throughput.

Parameters:
- xWIDTH, 8, dividend and quotient width.
- yWIDTH, 4, divisor and remainder width.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands x/y present.
- in_ready  output  1  controller can accept operands.
- x  input  xWIDTH  dividend.
- y  input  yWIDTH  divisor.
- out_valid  output  1  q/r/div0 valid.
- out_ready  input  1  consumer accepts result.
- q  output  xWIDTH  quotient.
- r  output  yWIDTH  remainder.
- div0  output  1  result came from a zero divisor.
- busy  output  1  state != IDLE.

Behaviour:
- Reset (async, rst=1): state=IDLE; in_ready=1; out_valid=0; q=0; r=0; div0=0; busy=0; bit counter=0. Internal x/y/partial-remainder registers are cleared.
- Reset mid-operation aborts immediately. There is no partial output; the first cycle after release is IDLE.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready at a clock edge: latch x and y; clear the partial remainder (yWIDTH+1 bits); set the counter to xWIDTH-1.
  - If y==0, go to DONE; otherwise go to RUN.
- RUN, one cycle per counter value, counter = xWIDTH-1 down to 0:
  - trial = {rem[yWIDTH-1:0], x[counter]}, which is yWIDTH+1 bits.
  - If trial >= {1'b0,y}: rem=trial-y and q[counter]=1. Otherwise rem=trial and q[counter]=0.
  - When counter==0, go to DONE. Otherwise decrement the counter.
  - in_ready=0.
- DONE:
  - out_valid=1; q and r=rem[yWIDTH-1:0] are held stable.
  - On out_ready, go to IDLE.
  - in_ready=0, so no new operand is accepted while the result is pending.
- Latency, normal path: out_valid rises on the (xWIDTH+1)-th edge after the accepting edge, i.e. after 9 edges at default widths.
- Throughput: one division per xWIDTH+2 cycles when out_ready is tied high.
- Divide by zero (y==0): DONE on the next edge, with q={xWIDTH{1'b1}}, r=x[yWIDTH-1:0], div0=1. div0=0 for every other result.
- Back-pressure: out_valid stays high and q/r/div0 stay frozen indefinitely until out_ready=1. This holds even if in_valid toggles meanwhile.
- out_ready while out_valid=0 is ignored.
- out_valid and in_ready are never both high.
- Result contract: the results match x/y and x%y for all x < 2^xWIDTH and 1 <= y < 2^yWIDTH.

Optional Feature:
- Macro: MATH_DIVIDER_SEQ_EARLY_EXIT_EN.
- Defined: at acceptance, if y!=0 and x<y, skip RUN and go to DONE next edge with q=0, r=x[yWIDTH-1:0], div0=0 (latency 1).
- Not defined: such operands take the full RUN sequence (latency xWIDTH+1). The numeric results are identical either way.

Decomposition:
- Package math_divider_pkg:
  - State encoding constants: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - Default width constants XWIDTH_DEF=8 and YWIDTH_DEF=4.
  - Counter-width function clog2.
- One sub-module, math_divider_attempt_subtr_stage:
  - Combinational: inputs rem_in[yWIDTH-1:0], x_bit, y.
  - Outputs rem_out[yWIDTH-1:0] and q_bit.
  - The controller instantiates it once and feeds it from its registers.

Test Plan:
- x=200, y=7, out_ready=1 -> out_valid on the 9th edge after acceptance; q=28, r=4, div0=0; busy high throughout.
- x=37, y=0 -> out_valid on the 1st edge; q=255, r=5, div0=1.
- x=200, y=7, out_ready held 0 for 5 cycles after out_valid, in_valid pulsed meanwhile -> q/r stable, in_ready=0, no new capture; the extra request is accepted only after the out_ready handshake.
- rst asserted during RUN at counter=3 -> all outputs 0 and state IDLE asynchronously; a new request 255/15 afterward -> q=17, r=0.
- x=5, y=9 -> q=0, r=5; out_valid on the 1st edge with MATH_DIVIDER_SEQ_EARLY_EXIT_EN defined, on the 9th edge without it.
- Exhaustive sweep: x=0..255, y=1..15, random out_ready stalls -> every result equals x/y and x%y; print "EOT" at the end.
